// File: rtl/elastic_reg_pipe.sv
// -----------------------------------------------------------------------------
// elastic_reg_pipe
//   Chain of DEPTH valid/ready register stages. An empty stage always accepts
//   data from upstream, so bubbles close up even while the output is stalled.
//   With out_ready=1 the chain sustains one transfer per cycle.
//
// Parameters
//   WIDTH    data width in bits (1..64)
//   DEPTH    number of register stages (1..16)
//   RST_VAL  value loaded into every data register on reset or flush
//
// Ports
//   clk        clock; all state updates on the rising edge
//   areset     asynchronous, active-high reset; empties the pipe
//   flush      synchronous clear, active-high; overrides all handshakes
//   in_valid   upstream data valid
//   in_ready   stage 0 can take in_data this cycle (combinational)
//   in_data    upstream data
//   out_valid  last stage holds valid data (registered)
//   out_ready  downstream accepts out_data
//   out_data   data from the last stage (registered)
//   occ        number of valid stages (only with ELASTIC_REG_PIPE_OCC_EN)
//
// Build option
//   ELASTIC_REG_PIPE_OCC_EN  when defined, adds the registered occ output.
// -----------------------------------------------------------------------------
module elastic_reg_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_REG_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Elaboration-time parameter range guard.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("elastic_reg_pipe: WIDTH must be in 1..64");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("elastic_reg_pipe: DEPTH must be in 1..16");
  end

  // Stage state: v_q[i]/d_q[i] is stage i; index 0 faces the input.
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // What each stage sees from upstream: the input port for stage 0,
  // the previous stage otherwise.
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // rdy[i]: stage i may load this edge; rdy[DEPTH] is the downstream ready.
  logic [DEPTH:0] rdy;

  // Upstream view per stage.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end
  end

  // Ready ripples back from the output: a stage can load when it is empty
  // or when its own content is leaving this edge.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = !v_q[i] || rdy[i+1];
    end
  end

  assign in_ready = rdy[0] && !flush;

  // Next-state: flush clears everything; otherwise each ready stage takes
  // upstream valid, and its data only when that valid is set (data holds
  // across bubbles so the register does not toggle needlessly).
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_d[i] = RST_VAL;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_d[i] = up_v[i];
          if (up_v[i]) begin
            d_d[i] = up_d[i];
          end
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= RST_VAL;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef ELASTIC_REG_PIPE_OCC_EN
  // Occupancy is registered from the next-state valids so it moves on the
  // same edge as the stages themselves.
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`else
  // Keep OCC_W referenced in the default build.
  logic [OCC_W-1:0] occ_unused;
  assign occ_unused = '0;
`endif

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_elastic_reg_pipe
//   Self-checking bench for elastic_reg_pipe (WIDTH=8, DEPTH=3, RST_VAL=0).
//   Reference model: an ordered list of in-flight items, each with a slot
//   position; every cycle the oldest item may leave, then each item steps one
//   slot forward if the slot ahead is free. occ is checked when
//   ELASTIC_REG_PIPE_OCC_EN is defined.
// -----------------------------------------------------------------------------
module tb_elastic_reg_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic         clk = 1'b0;
  logic         areset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef ELASTIC_REG_PIPE_OCC_EN
  logic [$clog2(D+1)-1:0] occ;
`endif

  always #5 clk = ~clk;

  elastic_reg_pipe #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ELASTIC_REG_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } item_t;

  item_t        q[$];       // in-flight items, oldest first
  logic [W-1:0] sent_q[$];  // accepted at the input
  logic [W-1:0] got_q[$];   // taken at the output
  logic         last_acc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (q.size() > 0) && (q[0].pos == int'(D) - 1);
    check("out_valid", out_valid, ev);
    if (ev) check("out_data", out_data, q[0].data);
`ifdef ELASTIC_REG_PIPE_OCC_EN
    check("occ", occ, q.size());
`endif
  endtask

  // Drive one cycle (called at the falling edge), check, advance the model.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    item_t nq[$];
    int    lim;
    int    np;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    lim = int'(D);
    foreach (q[k]) begin
      if (k == 0 && q[k].pos == int'(D) - 1 && ordy) continue;
      np  = (q[k].pos + 1 < lim) ? q[k].pos + 1 : q[k].pos;
      lim = np;
      nq.push_back('{data: q[k].data, pos: np});
    end
    check("in_ready", in_ready, (lim > 0) && !fl);
    if (out_valid && ordy && !fl) got_q.push_back(out_data);
    last_acc = iv && (lim > 0) && !fl;
    if (fl) begin
      nq.delete();
    end else if (last_acc) begin
      nq.push_back('{data: id, pos: 0});
      sent_q.push_back(id);
    end
    @(posedge clk);
    q = nq;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] bp_exp [4];
    int           guard;
    bp_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset values, visible without a clock edge.
    areset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef ELASTIC_REG_PIPE_OCC_EN
    check("rst_occ", occ, 0);
`endif
    repeat (2) @(negedge clk);
    areset = 1'b0;

    // Single item latency.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(2);
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_data, 8'hA5);
    idle(1);
    check("lat_gone", out_valid, 1'b0);

    // Back-to-back stream.
    got_q.delete(); sent_q.delete();
    for (int v = 1; v <= 16; v++) cycle(1'b1, W'(v), 1'b1, 1'b0);
    idle(int'(D) + 1);
    check("stream_count", got_q.size(), 16);
    foreach (got_q[k]) check("stream_data", got_q[k], k + 1);

    // Back-pressure: fill while stalled, then release.
    got_q.delete();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
    #1;
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_hold_data", out_data, 8'h11);
`ifdef ELASTIC_REG_PIPE_OCC_EN
    check("bp_occ", occ, 3);
`endif
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("bp_still_held", out_data, 8'h11);
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 10) begin
      cycle(1'b1, 8'h44, 1'b1, 1'b0);
      guard++;
    end
    check("bp_44_accepted", last_acc, 1'b1);
    idle(int'(D) + 1);
    check("bp_count", got_q.size(), 4);
    foreach (got_q[k]) if (k < 4) check("bp_order", got_q[k], bp_exp[k]);

    // Flush a full pipe; the input offered in the flush cycle is dropped.
    got_q.delete();
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_data", out_data, 8'h00);
`ifdef ELASTIC_REG_PIPE_OCC_EN
    check("flush_occ", occ, 0);
`endif
    idle(int'(D) + 1);
    check("flush_nothing_out", got_q.size(), 0);

    // Asynchronous reset between clock edges, mid-stream.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    #2 areset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 8'h00);
    check("arst_in_ready", in_ready, 1'b1);
`ifdef ELASTIC_REG_PIPE_OCC_EN
    check("arst_occ", occ, 0);
`endif
    q.delete(); got_q.delete();
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    idle(int'(D) + 2);
    check("arst_no_stale", got_q.size(), 0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    idle(2);
    check("arst_lat_valid", out_valid, 1'b1);
    check("arst_lat_data", out_data, 8'h3C);
    idle(int'(D));

    // Random valid/ready traffic, 1000 items.
    sent_q.delete(); got_q.delete();
    guard = 0;
    while (sent_q.size() < 1000 && guard < 20000) begin
      cycle(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      guard++;
    end
    idle(int'(D) + 2);
    check("rnd_sent", sent_q.size(), 1000);
    check("rnd_got", got_q.size(), sent_q.size());
    foreach (got_q[k]) if (k < sent_q.size()) check("rnd_order", got_q[k], sent_q[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_reg_pipe.md
ELASTIC_REG_PIPE -- requirements
Module: elastic_reg_pipe

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 2, number of register stages (1..16).
REQ-003 Parameter RST_VAL SHALL be: RST_VAL, default 0, WIDTH-bit value loaded into every data register on reset or flush.
REQ-004 Port clk SHALL be: clk  input  1  clock; all state updates on rising edge.
REQ-005 Port areset SHALL be: areset  input  1  reset, asynchronous, active-high.
REQ-006 Port flush SHALL be: flush  input  1  synchronous pipeline clear, active-high.
REQ-007 Port in_valid SHALL be: in_valid  input  1  upstream data valid.
REQ-008 Port in_ready SHALL be: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port in_data SHALL be: in_data  input  WIDTH  upstream data.
REQ-010 Port out_valid SHALL be: out_valid  output  1  out_data valid.
REQ-011 Port out_ready SHALL be: out_ready  input  1  downstream accepts out_data.
REQ-012 Port out_data SHALL be: out_data  output  WIDTH  data from last stage.
REQ-013 Port occ SHALL be: occ  output  clog2(DEPTH+1)  count of valid stages (present only with ELASTIC_REG_PIPE_OCC_EN).

Function
REQ-014 Block SHALL hold DEPTH stages S0..S(DEPTH-1), each a valid bit v[i] and WIDTH-bit data register d[i]; S0 faces input, S(DEPTH-1) faces output.
REQ-015 Stage ready SHALL be r[i] = !v[i] | r[i+1], with r[DEPTH] = out_ready; in_ready = r[0] & !flush.
REQ-016 When r[i]=1 and flush=0, stage i SHALL load v[i] <= upstream valid (in_valid for S0, v[i-1] otherwise); d[i] loads upstream data only when upstream valid=1, else holds.
REQ-017 When r[i]=0, stage i SHALL hold v[i] and d[i] unchanged.
REQ-018 out_valid SHALL equal v[DEPTH-1]; out_data SHALL equal d[DEPTH-1]; both registered, no combinational path from in_data.
REQ-019 Transfer SHALL occur on a rising edge where valid & ready are both 1, at input and output independently.
REQ-020 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid on an empty pipe with out_ready=1.
REQ-021 Throughput SHALL be one transfer per cycle sustained while out_ready=1, including simultaneous input and output transfer when full.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable until transfer.
REQ-023 Full pipe (all v=1) with out_ready=0 SHALL deassert in_ready in the same cycle; no data lost or duplicated.
REQ-024 Bubbles SHALL collapse: an empty stage accepts upstream data even while downstream is stalled.
REQ-025 flush=1 SHALL, at next edge, clear all v[i] to 0 and load all d[i] with RST_VAL; input data in that cycle is discarded; flush overrides all handshakes.
REQ-026 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-027 areset=1 SHALL immediately, without clk, set all v[i]=0, all d[i]=RST_VAL, so out_valid=0, out_data=RST_VAL, occ=0.
REQ-028 areset asserted mid-transfer SHALL discard all in-flight data; first accepted input after release appears after DEPTH cycles.
REQ-029 in_ready SHALL be 1 during and after reset (unless flush=1), since the pipe is empty.

Configuration
REQ-030 Macro ELASTIC_REG_PIPE_OCC_EN defined SHALL add port occ = number of v[i] set, updated on the same edge as v, 0 on reset/flush, range 0..DEPTH.
REQ-031 Macro ELASTIC_REG_PIPE_OCC_EN undefined SHALL remove port occ and its logic; all other behaviour identical.

Verification (WIDTH=8, DEPTH=3, RST_VAL=8'h00, OCC_EN defined)
REQ-032 Reset then in 8'hA5 at cycle 0, out_ready=1 -> out_valid=1, out_data=8'hA5 at cycle 3; occ 1,1,1,0.
REQ-033 Stream 8'h01..8'h10 back-to-back, out_ready=1 -> outputs 8'h01..8'h10 in order on consecutive cycles, in_ready never 0.
REQ-034 out_ready=0, push 8'h11,8'h22,8'h33,8'h44 -> first three accepted, in_ready=0 at 4th, occ=3, out_data held 8'h11; release -> 8'h11,8'h22,8'h33,8'h44 emitted.
REQ-035 Pipe holding 3 items, flush=1 one cycle -> next cycle out_valid=0, occ=0, out_data=8'h00, in-cycle input dropped.
REQ-036 areset pulse mid-stream, between clk edges -> out_valid=0, out_data=8'h00 immediately; no pre-reset item emitted afterwards.
REQ-037 Random valid/ready toggling, 1000 items -> scoreboard exact order, no loss/duplication, occ matches model every cycle.
